// File: rtl/btb_update_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// btb_update_ctrl_pkg
//   Shared definitions for the branch-resolution / BTB update controller:
//   machine word size, the empty-entry target sentinel, the conditional branch
//   opcodes, the controller FSM state encodings and a helper that resolves the
//   architecturally correct next PC of a control-flow instruction.
// -----------------------------------------------------------------------------
package btb_update_ctrl_pkg;

  localparam int WORD_SIZE = 16;
  localparam int BTB_IDX_W = 8;
  localparam int BTB_TAG_W = WORD_SIZE - BTB_IDX_W;

  // Target value marking an empty BTB entry. It can never be stored as a
  // real target, because a lookup hit on it would read as "no entry".
  localparam logic [WORD_SIZE-1:0] DEF_INVALID_TGT = 16'hFFFF;

  // Conditional branch opcodes.
  localparam logic [3:0] OP_BNE = 4'h8;
  localparam logic [3:0] OP_BEQ = 4'h9;
  localparam logic [3:0] OP_BGZ = 4'hA;
  localparam logic [3:0] OP_BLZ = 4'hB;

  // Controller FSM state encodings.
  localparam logic [1:0] ST_INIT   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_SQUASH = 2'd2;

  // Outcome of a resolved control-flow instruction.
  typedef struct packed {
    logic                 taken;       // control actually leaves the fall-through path
    logic                 cond_branch; // direction counter must be trained
    logic [WORD_SIZE-1:0] correct_pc;  // architecturally correct next PC
  } resolve_t;

  function automatic logic is_cond_branch_op(input logic [3:0] op);
    return (op == OP_BNE) || (op == OP_BEQ) || (op == OP_BGZ) || (op == OP_BLZ);
  endfunction

  // A jump wins over a branch when both flags are set, so such an
  // instruction is always taken and never trains the direction counter.
  function automatic resolve_t resolve(
    input logic                 is_branch,
    input logic                 is_jump,
    input logic                 taken,
    input logic [WORD_SIZE-1:0] pc,
    input logic [WORD_SIZE-1:0] target
  );
    resolve_t r;
    r.taken       = is_jump || (is_branch && taken);
    r.cond_branch = is_branch && !is_jump;
    // Fall-through wraps naturally at the top of the address space.
    r.correct_pc  = r.taken ? target : (pc + 16'd1);
    return r;
  endfunction

  // Saturating increment for the mispredict statistics counter.
  function automatic logic [WORD_SIZE-1:0] sat_inc(input logic [WORD_SIZE-1:0] v);
    return (v == {WORD_SIZE{1'b1}}) ? v : (v + 16'd1);
  endfunction

endpackage

// File: rtl/btb_update_ctrl.sv
// -----------------------------------------------------------------------------
// btb_update_ctrl
//   Resolves control-flow instructions at execute, detects mispredictions,
//   squashes the wrong-path slot, and generates BTB write / direction-counter
//   update strobes. After reset the BTB is swept clean (every entry gets tag 0
//   and the invalid-target sentinel) before normal operation begins.
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   synchronous active-high reset
//   res_valid     in   resolved control-flow instruction present
//   res_is_branch in   conditional branch
//   res_is_jump   in   unconditional jump (wins over res_is_branch)
//   res_taken     in   branch direction
//   res_pc        in   PC of the resolved instruction
//   res_target    in   taken target
//   res_pred_pc   in   next PC the predictor supplied
//   busy          out  init sweep in progress
//   flush         out  one-cycle squash pulse on mispredict
//   redirect_pc   out  correct next PC, valid with flush
//   btb_we        out  BTB write strobe
//   btb_index     out  BTB write index (PC[7:0])
//   btb_tag       out  BTB write tag   (PC[15:8])
//   btb_target    out  BTB write target
//   upd_valid     out  direction counter update strobe
//   upd_taken     out  direction counter update direction
//   mispred_cnt   out  saturating mispredict count
//
// Every output is registered: a response appears one cycle after the
// res_valid sample.
// -----------------------------------------------------------------------------
module btb_update_ctrl
  import btb_update_ctrl_pkg::*;
#(
  parameter int                   BTB_DEPTH   = 256,
  parameter logic [WORD_SIZE-1:0] INVALID_TGT = DEF_INVALID_TGT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 res_valid,
  input  logic                 res_is_branch,
  input  logic                 res_is_jump,
  input  logic                 res_taken,
  input  logic [WORD_SIZE-1:0] res_pc,
  input  logic [WORD_SIZE-1:0] res_target,
  input  logic [WORD_SIZE-1:0] res_pred_pc,
  output logic                 busy,
  output logic                 flush,
  output logic [WORD_SIZE-1:0] redirect_pc,
  output logic                 btb_we,
  output logic [BTB_IDX_W-1:0] btb_index,
  output logic [BTB_TAG_W-1:0] btb_tag,
  output logic [WORD_SIZE-1:0] btb_target,
  output logic                 upd_valid,
  output logic                 upd_taken,
  output logic [WORD_SIZE-1:0] mispred_cnt
);

  localparam logic [BTB_IDX_W-1:0] LAST_IDX = BTB_IDX_W'(BTB_DEPTH - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]           state_q,       state_d;
  logic [BTB_IDX_W-1:0] sweep_idx_q,   sweep_idx_d;
  logic                 busy_q,        busy_d;
  logic                 flush_q,       flush_d;
  logic [WORD_SIZE-1:0] redirect_q,    redirect_d;
  logic                 btb_we_q,      btb_we_d;
  logic [BTB_IDX_W-1:0] btb_index_q,   btb_index_d;
  logic [BTB_TAG_W-1:0] btb_tag_q,     btb_tag_d;
  logic [WORD_SIZE-1:0] btb_target_q,  btb_target_d;
  logic                 upd_valid_q,   upd_valid_d;
  logic                 upd_taken_q,   upd_taken_d;
  logic [WORD_SIZE-1:0] mispred_cnt_q, mispred_cnt_d;

  // ---------------------------------------------------------------------------
  // Resolution of the presented instruction
  // ---------------------------------------------------------------------------
  resolve_t res;
  logic     mispredict;
  logic     btb_write_ok;

  always_comb begin
    res          = resolve(res_is_branch, res_is_jump, res_taken, res_pc, res_target);
    mispredict   = res_valid && (res_pred_pc != res.correct_pc);
    // A taken target equal to the sentinel cannot be stored: the entry
    // would read back as empty.
    btb_write_ok = res_valid && res.taken && (res_target != INVALID_TGT);
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    sweep_idx_d   = sweep_idx_q;
    flush_d       = 1'b0;
    redirect_d    = redirect_q;
    btb_we_d      = 1'b0;
    btb_index_d   = btb_index_q;
    btb_tag_d     = btb_tag_q;
    btb_target_d  = btb_target_q;
    upd_valid_d   = 1'b0;
    upd_taken_d   = 1'b0;
    mispred_cnt_d = mispred_cnt_q;

    case (state_q)
      ST_INIT: begin
        // Clear one entry per cycle; res_valid is not looked at here.
        btb_we_d     = 1'b1;
        btb_index_d  = sweep_idx_q;
        btb_tag_d    = '0;
        btb_target_d = INVALID_TGT;
        if (sweep_idx_q == LAST_IDX) begin
          state_d     = ST_RUN;
          sweep_idx_d = '0;
        end else begin
          sweep_idx_d = sweep_idx_q + 1'b1;
        end
      end

      ST_RUN: begin
        if (res_valid) begin
          if (btb_write_ok) begin
            btb_we_d     = 1'b1;
            btb_index_d  = res_pc[BTB_IDX_W-1:0];
            btb_tag_d    = res_pc[WORD_SIZE-1:BTB_IDX_W];
            btb_target_d = res_target;
          end
          if (res.cond_branch) begin
            upd_valid_d = 1'b1;
            upd_taken_d = res_taken;
          end
          if (mispredict) begin
            flush_d       = 1'b1;
            redirect_d    = res.correct_pc;
            mispred_cnt_d = sat_inc(mispred_cnt_q);
            state_d       = ST_SQUASH;
          end
        end
      end

      ST_SQUASH: begin
        // The slot behind a mispredict is on the wrong path; drop it.
        state_d = ST_RUN;
      end

      default: begin
        state_d     = ST_INIT;
        sweep_idx_d = '0;
      end
    endcase

    // busy tracks the state the FSM is entering, so it drops together with
    // the first RUN cycle rather than one cycle later.
    busy_d = (state_d == ST_INIT);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_INIT;
      sweep_idx_q   <= '0;
      busy_q        <= 1'b1;
      flush_q       <= 1'b0;
      redirect_q    <= '0;
      btb_we_q      <= 1'b0;
      btb_index_q   <= '0;
      btb_tag_q     <= '0;
      btb_target_q  <= '0;
      upd_valid_q   <= 1'b0;
      upd_taken_q   <= 1'b0;
      mispred_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      sweep_idx_q   <= sweep_idx_d;
      busy_q        <= busy_d;
      flush_q       <= flush_d;
      redirect_q    <= redirect_d;
      btb_we_q      <= btb_we_d;
      btb_index_q   <= btb_index_d;
      btb_tag_q     <= btb_tag_d;
      btb_target_q  <= btb_target_d;
      upd_valid_q   <= upd_valid_d;
      upd_taken_q   <= upd_taken_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy        = busy_q;
  assign flush       = flush_q;
  assign redirect_pc = redirect_q;
  assign btb_we      = btb_we_q;
  assign btb_index   = btb_index_q;
  assign btb_tag     = btb_tag_q;
  assign btb_target  = btb_target_q;
  assign upd_valid   = upd_valid_q;
  assign upd_taken   = upd_taken_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_btb_update_ctrl.sv
module tb_btb_update_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        res_valid;
  logic        res_is_branch;
  logic        res_is_jump;
  logic        res_taken;
  logic [15:0] res_pc;
  logic [15:0] res_target;
  logic [15:0] res_pred_pc;
  logic        busy;
  logic        flush;
  logic [15:0] redirect_pc;
  logic        btb_we;
  logic [7:0]  btb_index;
  logic [7:0]  btb_tag;
  logic [15:0] btb_target;
  logic        upd_valid;
  logic        upd_taken;
  logic [15:0] mispred_cnt;

  always #5 clk = ~clk;

  btb_update_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .res_valid    (res_valid),
    .res_is_branch(res_is_branch),
    .res_is_jump  (res_is_jump),
    .res_taken    (res_taken),
    .res_pc       (res_pc),
    .res_target   (res_target),
    .res_pred_pc  (res_pred_pc),
    .busy         (busy),
    .flush        (flush),
    .redirect_pc  (redirect_pc),
    .btb_we       (btb_we),
    .btb_index    (btb_index),
    .btb_tag      (btb_tag),
    .btb_target   (btb_target),
    .upd_valid    (upd_valid),
    .upd_taken    (upd_taken),
    .mispred_cnt  (mispred_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: just "is the next slot squashed" and the mispredict tally.
  bit          m_squash;
  int          m_cnt;
  logic        e_flush, e_we, e_upd, e_upd_taken;
  logic [15:0] e_redirect, e_target;
  logic [7:0]  e_index, e_tag;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    res_valid     = 1'b0;
    res_is_branch = 1'b0;
    res_is_jump   = 1'b0;
    res_taken     = 1'b0;
    res_pc        = 16'h0000;
    res_target    = 16'h0000;
    res_pred_pc   = 16'h0000;
  endtask

  // Expected response to one presented slot, from the architectural rules.
  task automatic model_step(input bit v, input bit br, input bit jp, input bit tk,
                            input logic [15:0] pc, input logic [15:0] tgt,
                            input logic [15:0] pred);
    bit          is_taken;
    logic [15:0] next_pc;
    e_flush = 1'b0;
    e_we    = 1'b0;
    e_upd   = 1'b0;
    if (m_squash) begin
      m_squash = 1'b0;
    end else if (v) begin
      is_taken = jp || (br && tk);
      next_pc  = is_taken ? tgt : 16'(pc + 16'd1);
      if (pred != next_pc) begin
        e_flush    = 1'b1;
        e_redirect = next_pc;
        if (m_cnt < 65535) m_cnt++;
        m_squash   = 1'b1;
      end
      if (is_taken && tgt != 16'hFFFF) begin
        e_we     = 1'b1;
        e_index  = pc[7:0];
        e_tag    = pc[15:8];
        e_target = tgt;
      end
      if (br && !jp) begin
        e_upd       = 1'b1;
        e_upd_taken = tk;
      end
    end
  endtask

  task automatic check_run(input string name);
    chk($sformatf("%s.busy", name),        32'(busy),        32'(0));
    chk($sformatf("%s.flush", name),       32'(flush),       32'(e_flush));
    chk($sformatf("%s.btb_we", name),      32'(btb_we),      32'(e_we));
    chk($sformatf("%s.upd_valid", name),   32'(upd_valid),   32'(e_upd));
    chk($sformatf("%s.mispred_cnt", name), 32'(mispred_cnt), 32'(m_cnt));
    if (e_flush) chk($sformatf("%s.redirect", name), 32'(redirect_pc), 32'(e_redirect));
    if (e_we) begin
      chk($sformatf("%s.btb_index", name),  32'(btb_index),  32'(e_index));
      chk($sformatf("%s.btb_tag", name),    32'(btb_tag),    32'(e_tag));
      chk($sformatf("%s.btb_target", name), 32'(btb_target), 32'(e_target));
    end
    if (e_upd) chk($sformatf("%s.upd_taken", name), 32'(upd_taken), 32'(e_upd_taken));
  endtask

  // One transaction: drive at a falling edge, let the DUT sample, check at the
  // next falling edge.
  task automatic apply(input string name, input bit v, input bit br, input bit jp,
                       input bit tk, input logic [15:0] pc, input logic [15:0] tgt,
                       input logic [15:0] pred);
    res_valid     = v;
    res_is_branch = br;
    res_is_jump   = jp;
    res_taken     = tk;
    res_pc        = pc;
    res_target    = tgt;
    res_pred_pc   = pred;
    model_step(v, br, jp, tk, pc, tgt, pred);
    @(negedge clk);
    $display("txn %s: v=%0b br=%0b jp=%0b tk=%0b pc=%h tgt=%h pred=%h -> flush=%0b redir=%h we=%0b idx=%h tag=%h tgt=%h upd=%0b/%0b cnt=%h",
             name, v, br, jp, tk, pc, tgt, pred, flush, redirect_pc, btb_we, btb_index,
             btb_tag, btb_target, upd_valid, upd_taken, mispred_cnt);
    check_run(name);
  endtask

  task automatic do_reset(input string name);
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    chk($sformatf("%s.rst_busy", name),     32'(busy),        32'(1));
    chk($sformatf("%s.rst_flush", name),    32'(flush),       32'(0));
    chk($sformatf("%s.rst_redirect", name), 32'(redirect_pc), 32'(0));
    chk($sformatf("%s.rst_btb_we", name),   32'(btb_we),      32'(0));
    chk($sformatf("%s.rst_upd_valid", name),32'(upd_valid),   32'(0));
    chk($sformatf("%s.rst_upd_taken", name),32'(upd_taken),   32'(0));
    chk($sformatf("%s.rst_cnt", name),      32'(mispred_cnt), 32'(0));
    reset    = 1'b0;
    m_squash = 1'b0;
    m_cnt    = 0;
  endtask

  // Sweep entries 0..last_idx, with random garbage on the resolution inputs
  // that must be ignored.
  task automatic check_sweep(input string name, input int last_idx);
    for (int i = 0; i <= last_idx; i++) begin
      res_valid     = 1'($urandom_range(0, 1));
      res_is_branch = 1'($urandom_range(0, 1));
      res_is_jump   = 1'($urandom_range(0, 1));
      res_taken     = 1'($urandom_range(0, 1));
      res_pc        = 16'($urandom);
      res_target    = 16'($urandom);
      res_pred_pc   = 16'($urandom);
      @(negedge clk);
      chk($sformatf("%s.sweep_we[%0d]", name, i),     32'(btb_we),     32'(1));
      chk($sformatf("%s.sweep_index[%0d]", name, i),  32'(btb_index),  32'(i));
      chk($sformatf("%s.sweep_tag[%0d]", name, i),    32'(btb_tag),    32'(0));
      chk($sformatf("%s.sweep_target[%0d]", name, i), 32'(btb_target), 32'(16'hFFFF));
      chk($sformatf("%s.sweep_busy[%0d]", name, i),   32'(busy),       32'(i != 255));
      chk($sformatf("%s.sweep_flush[%0d]", name, i),  32'(flush),      32'(0));
      chk($sformatf("%s.sweep_upd[%0d]", name, i),    32'(upd_valid),  32'(0));
    end
    idle_inputs();
  endtask

  initial begin
    bit          v, br, jp, tk, taken;
    logic [15:0] pc, tgt, pred, corr;

    idle_inputs();
    reset = 1'b1;
    m_squash = 1'b0;
    m_cnt = 0;

    // Reset, partial sweep, reset mid-sweep at index 100, full sweep.
    do_reset("por");
    check_sweep("part", 100);
    do_reset("midsweep");
    check_sweep("full", 255);

    // Idle RUN cycle: nothing fires, busy stays low.
    apply("idle", 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);

    // Taken branch, mispredicted.
    apply("br_taken_mis", 1, 1, 0, 1, 16'h1234, 16'h1240, 16'h1235);
    chk("br_taken_mis.const_redirect", 32'(redirect_pc), 32'(16'h1240));
    chk("br_taken_mis.const_index",    32'(btb_index),   32'(8'h34));
    chk("br_taken_mis.const_tag",      32'(btb_tag),     32'(8'h12));
    chk("br_taken_mis.const_upd_tk",   32'(upd_taken),   32'(1));
    chk("br_taken_mis.const_cnt",      32'(mispred_cnt), 32'(1));

    // Slot right after the mispredict is squashed; the one after is processed.
    apply("squashed", 1, 0, 1, 0, 16'h2000, 16'h3000, 16'h2001);
    chk("squashed.const_flush", 32'(flush),  32'(0));
    chk("squashed.const_we",    32'(btb_we), 32'(0));
    apply("after_squash", 1, 1, 0, 1, 16'h0400, 16'h0480, 16'h0480);
    chk("after_squash.const_we", 32'(btb_we), 32'(1));

    // Correctly predicted not-taken branch.
    apply("br_nt_ok", 1, 1, 0, 0, 16'h0010, 16'h0050, 16'h0011);
    chk("br_nt_ok.const_upd",    32'(upd_valid), 32'(1));
    chk("br_nt_ok.const_upd_tk", 32'(upd_taken), 32'(0));

    // Jump at the top of the address space, then wrap of the fall-through.
    apply("jmp_ffff", 1, 0, 1, 0, 16'hFFFF, 16'h0005, 16'h0000);
    chk("jmp_ffff.const_redirect", 32'(redirect_pc), 32'(16'h0005));
    apply("jmp_ffff_sq", 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
    apply("br_wrap", 1, 1, 0, 0, 16'hFFFF, 16'h1000, 16'h0000);
    chk("br_wrap.const_flush", 32'(flush), 32'(0));

    // Taken target equal to the sentinel: redirect, but no BTB write.
    apply("jmp_inv", 1, 0, 1, 0, 16'h5555, 16'hFFFF, 16'h5556);
    chk("jmp_inv.const_we", 32'(btb_we), 32'(0));
    apply("jmp_inv_sq", 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);

    // Branch and jump both set: a taken jump, no counter update.
    apply("br_and_jmp", 1, 1, 1, 0, 16'h0A00, 16'h0B00, 16'h0B00);
    chk("br_and_jmp.const_we", 32'(btb_we), 32'(1));

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      v   = ($urandom_range(0, 3) != 0);
      br  = 1'($urandom_range(0, 1));
      jp  = ($urandom_range(0, 2) == 0);
      tk  = 1'($urandom_range(0, 1));
      pc  = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom);
      tgt = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      taken = jp || (br && tk);
      corr  = taken ? tgt : 16'(pc + 16'd1);
      pred  = ($urandom_range(0, 1) == 0) ? corr : 16'($urandom);
      apply($sformatf("rnd%0d", n), v, br, jp, tk, pc, tgt, pred);
    end

    // Saturation: preload near the top, then keep mispredicting.
    apply("pre_sat_idle", 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
    force dut.mispred_cnt_q = 16'hFFFD;
    #1;
    release dut.mispred_cnt_q;
    m_cnt = 65533;
    for (int k = 0; k < 3; k++) begin
      apply($sformatf("sat%0d", k), 1, 0, 1, 0, 16'h0100, 16'h0200, 16'h0101);
      apply($sformatf("sat%0d_sq", k), 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
    end
    chk("sat.const_cnt", 32'(mispred_cnt), 32'(16'hFFFF));

    // Reset while in SQUASH restarts the sweep from index 0.
    apply("pre_rst_mis", 1, 1, 0, 1, 16'h0700, 16'h0780, 16'h0701);
    do_reset("midsquash");
    check_sweep("resweep", 255);
    apply("final", 1, 0, 1, 0, 16'h0042, 16'h0099, 16'h0099);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
